// File: rtl/nba_commit_scheduler.sv
// Circular {addr,data} queue with occupancy count for deferred register writes.
// Latency: an entry pushed at edge E is at the head from E+1 onward.
// Backpressure: push_rdy=0 when full; a push while full is dropped even if that cycle pops.
module nba_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    output logic          push_rdy,
    input  logic [W-1:0]  push_dat,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign push_rdy = (count != FULL_CNT);
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[head];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && pop_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= (tail == LAST_PTR) ? '0 : tail + PW'(1);
            end
            if (do_pop) begin
                head <= (head == LAST_PTR) ? '0 : head + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[tail] <= push_dat;
        end
    end
endmodule

// Commits immediate and deferred writes to a small register file, one commit per cycle.
// Latency: immediate write commits on acceptance; deferred commits >=1 cycle after enqueue; upd one cycle after commit.
// Backpressure: blk_ready is the same-cycle grant; nba_ready drops while the deferred queue is full.
module nba_commit_scheduler #(
    parameter int WIDTH = 8,
    parameter int REGS  = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(REGS),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nba_first,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [AW-1:0]    blk_addr,
    input  logic [WIDTH-1:0] blk_data,
    input  logic             nba_valid,
    output logic             nba_ready,
    input  logic [AW-1:0]    nba_addr,
    input  logic [WIDTH-1:0] nba_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             upd_valid,
    output logic [AW-1:0]    upd_addr,
    output logic [WIDTH-1:0] upd_data,
    output logic [CW-1:0]    nba_count
);
    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } nba_ent_t;

    typedef enum logic {
        LAST_BLK = 1'b0,
        LAST_NBA = 1'b1
    } last_t;

    last_t            last_q;
    last_t            last_nxt;
    nba_ent_t         enq_ent;
    nba_ent_t         head_ent;
    logic             nba_pend;
    logic             blk_win;
    logic             nba_win;
    logic             commit;
    logic             changed;
    logic [AW-1:0]    cmt_addr;
    logic [WIDTH-1:0] cmt_data;
    logic [WIDTH-1:0] regs [REGS];

    assign enq_ent = '{addr: nba_addr, data: nba_data};

    nba_fifo #(
        .W     ($bits(nba_ent_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (nba_valid),
        .push_rdy (nba_ready),
        .push_dat (enq_ent),
        .pop_vld  (nba_pend),
        .pop_rdy  (nba_win),
        .pop_dat  (head_ent),
        .count    (nba_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= LAST_NBA;
        end else begin
            last_q <= last_nxt;
        end
    end

    // Reset state LAST_NBA hands the first fair-mode tie to the immediate class.
    always_comb begin
        blk_win  = 1'b0;
        nba_win  = 1'b0;
        last_nxt = last_q;
        if (nba_first) begin
            nba_win = nba_pend;
            blk_win = blk_valid && !nba_pend;
        end else if (blk_valid && nba_pend) begin
            blk_win = (last_q == LAST_NBA);
            nba_win = (last_q == LAST_BLK);
        end else begin
            blk_win = blk_valid;
            nba_win = nba_pend;
        end
        if (blk_win) begin
            last_nxt = LAST_BLK;
        end else if (nba_win) begin
            last_nxt = LAST_NBA;
        end
    end

    assign blk_ready = blk_win;
    assign commit    = blk_win || nba_win;
    assign cmt_addr  = blk_win ? blk_addr : head_ent.addr;
    assign cmt_data  = blk_win ? blk_data : head_ent.data;
    assign changed   = commit && (regs[cmt_addr] != cmt_data);
    assign rd_data   = regs[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
            upd_valid <= 1'b0;
            upd_addr  <= '0;
            upd_data  <= '0;
        end else begin
            if (commit) begin
                regs[cmt_addr] <= cmt_data;
            end
            upd_valid <= changed;
            if (changed) begin
                upd_addr <= cmt_addr;
                upd_data <= cmt_data;
            end
        end
    end
endmodule

// File: tb/tb_nba_commit_scheduler.sv
// Directed stimulus for nba_commit_scheduler with a queue-based reference model checked every cycle.
// Model state is "state after the next edge"; it is advanced at each falling edge after comparing.
module tb_nba_commit_scheduler;
    localparam int WIDTH = 8;
    localparam int REGS  = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             nba_first = 1'b0;
    logic             blk_valid = 1'b0;
    logic             nba_valid = 1'b0;
    logic [AW-1:0]    blk_addr = '0;
    logic [AW-1:0]    nba_addr = '0;
    logic [AW-1:0]    rd_addr = '0;
    logic [WIDTH-1:0] blk_data = '0;
    logic [WIDTH-1:0] nba_data = '0;
    logic             blk_ready;
    logic             nba_ready;
    logic             upd_valid;
    logic [AW-1:0]    upd_addr;
    logic [WIDTH-1:0] upd_data;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    nba_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int a;
        int d;
    } ent_t;

    int   m_regs [REGS];
    ent_t m_q [$];
    bit   m_last_blk = 1'b0;
    bit   m_upd = 1'b0;
    int   m_ua = 0;
    int   m_ud = 0;
    bit   m_live = 1'b0;
    bit   cap = 1'b0;
    int   acc [$];
    int   got [$];

    always #5 clk = ~clk;

    nba_commit_scheduler #(
        .WIDTH (WIDTH),
        .REGS  (REGS),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nba_first (nba_first),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_addr  (blk_addr),
        .blk_data  (blk_data),
        .nba_valid (nba_valid),
        .nba_ready (nba_ready),
        .nba_addr  (nba_addr),
        .nba_data  (nba_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .upd_valid (upd_valid),
        .upd_addr  (upd_addr),
        .upd_data  (upd_data),
        .nba_count (nba_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        blk_valid = 1'b0;
        nba_valid = 1'b0;
        nba_first = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : model
        bit   has;
        bit   bw;
        bit   nw;
        int   a;
        int   d;
        ent_t e;
        if (rst) begin
            m_q.delete();
            foreach (m_regs[i]) m_regs[i] = 0;
            m_last_blk = 1'b0;
            m_upd      = 1'b0;
            m_ua       = 0;
            m_ud       = 0;
            m_live     = 1'b1;
        end else if (m_live) begin
            has = (m_q.size() != 0);
            if (!blk_valid)     bw = 1'b0;
            else if (!has)      bw = 1'b1;
            else if (nba_first) bw = 1'b0;
            else                bw = !m_last_blk;
            nw = has && !bw;

            check("mdl_blk_ready", blk_ready, bw);
            check("mdl_nba_ready", nba_ready, m_q.size() != DEPTH);
            check("mdl_count", nba_count, m_q.size());
            check("mdl_rd_data", rd_data, m_regs[rd_addr]);
            check("mdl_upd_valid", upd_valid, m_upd);
            if (m_upd) begin
                check("mdl_upd_addr", upd_addr, m_ua);
                check("mdl_upd_data", upd_data, m_ud);
            end
            if (cap) begin
                if (nba_valid && nba_ready) acc.push_back(int'(nba_addr) * 256 + int'(nba_data));
                if (upd_valid && upd_data < 100) got.push_back(int'(upd_addr) * 256 + int'(upd_data));
            end

            a = 0;
            d = 0;
            if (bw) begin
                a = int'(blk_addr);
                d = int'(blk_data);
            end else if (nw) begin
                a = m_q[0].a;
                d = m_q[0].d;
            end
            m_upd = (bw || nw) && (m_regs[a] != d);
            if (m_upd) begin
                m_ua = a;
                m_ud = d;
            end
            if (bw || nw) begin
                m_regs[a]  = d;
                m_last_blk = bw;
            end
            if (nba_valid && m_q.size() != DEPTH) begin
                e.a = int'(nba_addr);
                e.d = int'(nba_data);
                m_q.push_back(e);
            end
            if (nw) void'(m_q.pop_front());
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int maxc;
        int sawfull;

        // Reset held two cycles under random input activity
        for (int i = 0; i < 2; i++) begin
            nba_first = 1'($urandom);
            blk_valid = 1'($urandom);
            nba_valid = 1'($urandom);
            blk_addr  = AW'($urandom);
            nba_addr  = AW'($urandom);
            blk_data  = WIDTH'($urandom);
            nba_data  = WIDTH'($urandom);
            cyc();
        end
        rst = 1'b0; blk_valid = 1'b0; nba_valid = 1'b0; nba_first = 1'b0;
        #1;
        check("rst_count", nba_count, 0);
        check("rst_nba_ready", nba_ready, 1);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_upd_addr", upd_addr, 0);
        check("rst_upd_data", upd_data, 0);
        for (int a = 0; a < REGS; a++) begin
            rd_addr = AW'(a);
            #1;
            check($sformatf("rst_rd%0d", a), rd_data, 0);
        end

        // Deferred-first: immediate write waits until the queue drains
        do_reset();
        nba_first = 1'b1; nba_valid = 1'b1; nba_addr = 0; nba_data = 0;
        cyc();
        nba_data = 1; blk_valid = 1'b1; blk_addr = 1; blk_data = 5;
        #1;
        check("nf_blk_ready_c1", blk_ready, 0);
        check("nf_count_c1", nba_count, 1);
        cyc();
        nba_valid = 1'b0;
        #1;
        check("nf_blk_ready_c2", blk_ready, 0);
        check("nf_no_upd_same", upd_valid, 0);
        cyc();
        check("nf_blk_ready_c3", blk_ready, 1);
        check("nf_upd0_valid", upd_valid, 1);
        check("nf_upd0_addr", upd_addr, 0);
        check("nf_upd0_data", upd_data, 1);
        cyc();
        blk_valid = 1'b0;
        check("nf_upd1_valid", upd_valid, 1);
        check("nf_upd1_addr", upd_addr, 1);
        check("nf_upd1_data", upd_data, 5);
        cyc();
        check("nf_upd_end", upd_valid, 0);

        // Fair mode: first tie after reset goes to BLK, then alternates
        do_reset();
        nba_valid = 1'b1; nba_addr = 3; nba_data = 40;
        cyc();
        blk_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            blk_addr = AW'(i);
            blk_data = WIDTH'(100 + i);
            nba_data = WIDTH'(41 + i);
            #1;
            check($sformatf("alt_grant%0d", i), blk_ready, (i % 2 == 0));
            cyc();
        end
        blk_valid = 1'b0; nba_valid = 1'b0;

        // Fill under fair contention; deferred commits must follow enqueue order
        do_reset();
        acc.delete(); got.delete();
        cap = 1'b1; blk_valid = 1'b1; nba_valid = 1'b1;
        maxc = 0; sawfull = 0;
        for (int i = 0; i < 14; i++) begin
            nba_addr = AW'(i);
            nba_data = WIDTH'(16 + i);
            blk_addr = AW'(i + 1);
            blk_data = WIDTH'(100 + i);
            #1;
            if (int'(nba_count) > maxc) maxc = int'(nba_count);
            if (nba_count == 3'd4 && !nba_ready) sawfull++;
            cyc();
        end
        blk_valid = 1'b0; nba_valid = 1'b0;
        for (int i = 0; i < 20 && nba_count != 0; i++) cyc();
        check("fill_drained", nba_count, 0);
        cyc(); cyc();
        cap = 1'b0;
        check("fill_max_count", maxc, 4);
        check("fill_ready_low", sawfull > 0, 1);
        check("fill_accepted", acc.size(), 10);
        check("fill_committed", got.size(), acc.size());
        for (int i = 0; i < acc.size(); i++) begin
            if (i < got.size()) check($sformatf("fill_order%0d", i), got[i], acc[i]);
        end

        // Reset with three entries pending discards them
        do_reset();
        blk_valid = 1'b1; nba_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nba_addr = AW'(i);
            nba_data = WIDTH'(50 + i);
            blk_addr = AW'(i + 2);
            blk_data = WIDTH'(110 + i);
            cyc();
        end
        check("mq_count3", nba_count, 3);
        rst = 1'b1; blk_valid = 1'b0; nba_valid = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        check("mq_count0", nba_count, 0);
        check("mq_ready", nba_ready, 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("mq_no_upd%0d", i), upd_valid, 0);
            cyc();
        end
        for (int a = 0; a < REGS; a++) begin
            rd_addr = AW'(a);
            #1;
            check($sformatf("mq_rd%0d", a), rd_data, 0);
        end

        // Same-value write is silent; a changing write pulses upd
        do_reset();
        blk_valid = 1'b1; blk_addr = 2; blk_data = 0;
        #1;
        check("sv_blk_ready", blk_ready, 1);
        cyc();
        blk_data = 7;
        #1;
        check("sv_no_upd", upd_valid, 0);
        cyc();
        blk_valid = 1'b0; rd_addr = 2;
        #1;
        check("sv_upd_valid", upd_valid, 1);
        check("sv_upd_addr", upd_addr, 2);
        check("sv_upd_data", upd_data, 7);
        check("sv_rd_data", rd_data, 7);
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
